// File: rtl/imem_pkg.sv
// Shared types, defaults and helpers for the synchronous instruction memory.
package imem_pkg;

    // Init/run state of the memory controller.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } imem_state_e;

    localparam int DEF_DEPTH  = 256;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 22;

    // Word returned on a faulting fetch (all-zero doubles as a NOP encoding).
    localparam logic [63:0] FAULT_WORD = 64'h0000_0000_0000_0000;

    // Number of byte-offset bits inside one instruction word.
    function automatic int calc_off(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch and program-load bus of the instruction memory.
interface instr_mem_sync_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 22
) ();
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ack;
    logic              prog_err;
    logic              init_busy;

    // Fetch unit / loader side.
    modport master (
        output fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
        input  fetch_ready, fetch_valid, fetch_data, fetch_fault,
               prog_ack, prog_err, init_busy
    );

    // Memory side.
    modport slave (
        input  fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
        output fetch_ready, fetch_valid, fetch_data, fetch_fault,
               prog_ack, prog_err, init_busy
    );
endinterface

// File: rtl/imem_ram.sv
// Single-write, single-registered-read RAM; a read and write to the same
// entry in one cycle returns the old contents (read-first).
module imem_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end
endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: registered fetch port, program-load port,
// alignment/range checking and a sequential clear after reset.
module instr_mem_sync
    import imem_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic             clk,
    input logic             reset,
    instr_mem_sync_if.slave bus
);
    localparam int OFF    = calc_off(DATA_W);
    localparam int IDX_W  = ADDR_W - OFF;
    localparam int RAM_AW = $clog2(DEPTH);

    imem_state_e       state_r;
    logic [RAM_AW-1:0] cnt_r;

    logic [IDX_W-1:0]  fetch_idx_s;
    logic [IDX_W-1:0]  prog_idx_s;
    logic              fetch_legal_s;
    logic              prog_legal_s;
    logic              fetch_acc_s;
    logic              prog_acc_s;

    logic              ram_we_s;
    logic [RAM_AW-1:0] ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic              ram_re_s;
    logic [DATA_W-1:0] ram_rdata_s;

    logic              fetch_valid_r;
    logic              fetch_fault_r;
    logic              data_zero_r;
    logic              prog_ack_r;
    logic              prog_err_r;

    assign fetch_idx_s = bus.fetch_addr[ADDR_W-1:OFF];
    assign prog_idx_s  = bus.prog_addr[ADDR_W-1:OFF];

    // Alignment and full-width range decode of both ports, plus acceptance.
    always_comb begin
        fetch_legal_s = 1'b0;
        prog_legal_s  = 1'b0;
        fetch_acc_s   = 1'b0;
        prog_acc_s    = 1'b0;
        if ((bus.fetch_addr[OFF-1:0] == {OFF{1'b0}}) && (64'(fetch_idx_s) < 64'(DEPTH))) begin
            fetch_legal_s = 1'b1;
        end else begin
            fetch_legal_s = 1'b0;
        end
        if ((bus.prog_addr[OFF-1:0] == {OFF{1'b0}}) && (64'(prog_idx_s) < 64'(DEPTH))) begin
            prog_legal_s = 1'b1;
        end else begin
            prog_legal_s = 1'b0;
        end
        if (state_r == RUN) begin
            fetch_acc_s = bus.fetch_req;
            prog_acc_s  = bus.prog_we;
        end else begin
            fetch_acc_s = 1'b0;
            prog_acc_s  = 1'b0;
        end
    end

    // RAM port steering; the clear sequence owns the write port while active.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = '0;
        ram_re_s    = fetch_acc_s & fetch_legal_s;
        if (state_r == CLEAR) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = cnt_r;
            ram_wdata_s = '0;
        end else begin
            ram_we_s    = prog_acc_s & prog_legal_s;
            ram_waddr_s = prog_idx_s[RAM_AW-1:0];
            ram_wdata_s = bus.prog_data;
        end
    end

    // Init FSM: walk the array once, then stay in RUN until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= CLEAR_ON_RESET ? CLEAR : RUN;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                CLEAR: begin
                    if (cnt_r == RAM_AW'(DEPTH - 1)) begin
                        state_r <= RUN;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + RAM_AW'(1);
                    end
                end
                RUN: begin
                    state_r <= RUN;
                    cnt_r   <= cnt_r;
                end
                default: begin
                    state_r <= RUN;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Fetch response and program acknowledge registers (one-cycle latency).
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
            data_zero_r   <= 1'b1;
            prog_ack_r    <= 1'b0;
            prog_err_r    <= 1'b0;
        end else begin
            fetch_valid_r <= fetch_acc_s;
            if (fetch_acc_s) begin
                fetch_fault_r <= ~fetch_legal_s;
                data_zero_r   <= ~fetch_legal_s;
            end else begin
                fetch_fault_r <= fetch_fault_r;
                data_zero_r   <= data_zero_r;
            end
            prog_ack_r <= prog_acc_s;
            prog_err_r <= prog_acc_s & ~prog_legal_s;
        end
    end

    imem_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (ram_re_s),
        .raddr (fetch_idx_s[RAM_AW-1:0]),
        .rdata (ram_rdata_s)
    );

    // The RAM read register has no reset, so a flag forces zero data after
    // reset and after a faulting fetch while the RAM output keeps its value.
    assign bus.fetch_data  = data_zero_r ? FAULT_WORD[DATA_W-1:0] : ram_rdata_s;
    assign bus.fetch_valid = fetch_valid_r;
    assign bus.fetch_fault = fetch_fault_r;
    assign bus.prog_ack    = prog_ack_r;
    assign bus.prog_err    = prog_err_r;
    assign bus.fetch_ready = (state_r == RUN);
    assign bus.init_busy   = (state_r == CLEAR);
endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench: DUT A (32-bit, clear on reset) and DUT B (64-bit,
// contents kept across reset), each with a scoreboard of expected responses.
module tb_instr_mem_sync;

    typedef struct packed {
        logic [63:0] data;
        logic        fault;
    } fexp_t;

    logic clk;
    logic reset_a;
    logic reset_b;
    int   n_checks;
    int   n_fail;

    fexp_t exp_fa_q[$];
    bit    exp_pa_q[$];
    fexp_t exp_fb_q[$];
    bit    exp_pb_q[$];

    logic [31:0] model_a [256];
    logic [63:0] model_b [16];

    instr_mem_sync_if #(.DATA_W(32), .ADDR_W(22)) bus_a ();
    instr_mem_sync_if #(.DATA_W(64), .ADDR_W(22)) bus_b ();

    instr_mem_sync #(.DEPTH(256), .DATA_W(32), .ADDR_W(22), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a)
    );
    instr_mem_sync #(.DEPTH(16), .DATA_W(64), .ADDR_W(22), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor for DUT A.
    always @(negedge clk) begin
        fexp_t fe;
        bit    pe;
        if (bus_a.fetch_valid === 1'b1) begin
            n_checks++;
            if (exp_fa_q.size() == 0) begin
                n_fail++;
                $display("FAIL a_fetch_unexpected: fetch_valid=1 data=%h, required no response", bus_a.fetch_data);
            end else begin
                fe = exp_fa_q.pop_front();
                if (bus_a.fetch_data !== fe.data[31:0] || bus_a.fetch_fault !== fe.fault) begin
                    n_fail++;
                    $display("FAIL a_fetch_data: got data=%h fault=%b, required data=%h fault=%b",
                             bus_a.fetch_data, bus_a.fetch_fault, fe.data[31:0], fe.fault);
                end
            end
        end
        if (bus_a.prog_ack === 1'b1) begin
            n_checks++;
            if (exp_pa_q.size() == 0) begin
                n_fail++;
                $display("FAIL a_prog_unexpected: prog_ack=1, required no ack");
            end else begin
                pe = exp_pa_q.pop_front();
                if (bus_a.prog_err !== pe) begin
                    n_fail++;
                    $display("FAIL a_prog_err: got %b, required %b", bus_a.prog_err, pe);
                end
            end
        end
    end

    // Scoreboard monitor for DUT B.
    always @(negedge clk) begin
        fexp_t fe;
        bit    pe;
        if (bus_b.fetch_valid === 1'b1) begin
            n_checks++;
            if (exp_fb_q.size() == 0) begin
                n_fail++;
                $display("FAIL b_fetch_unexpected: fetch_valid=1 data=%h, required no response", bus_b.fetch_data);
            end else begin
                fe = exp_fb_q.pop_front();
                if (bus_b.fetch_data !== fe.data || bus_b.fetch_fault !== fe.fault) begin
                    n_fail++;
                    $display("FAIL b_fetch_data: got data=%h fault=%b, required data=%h fault=%b",
                             bus_b.fetch_data, bus_b.fetch_fault, fe.data, fe.fault);
                end
            end
        end
        if (bus_b.prog_ack === 1'b1) begin
            n_checks++;
            if (exp_pb_q.size() == 0) begin
                n_fail++;
                $display("FAIL b_prog_unexpected: prog_ack=1, required no ack");
            end else begin
                pe = exp_pb_q.pop_front();
                if (bus_b.prog_err !== pe) begin
                    n_fail++;
                    $display("FAIL b_prog_err: got %b, required %b", bus_b.prog_err, pe);
                end
            end
        end
    end

    // One cycle of stimulus on DUT A; expectations come from the bench model
    // (fetch evaluated before the same-cycle write: read-first).
    task automatic drive_a(input bit f_en, input logic [21:0] f_addr, input bit p_en,
                           input logic [21:0] p_addr, input logic [31:0] p_data);
        fexp_t fe;
        int unsigned fidx;
        int unsigned pidx;
        bus_a.fetch_req  = f_en;
        bus_a.fetch_addr = f_addr;
        bus_a.prog_we    = p_en;
        bus_a.prog_addr  = p_addr;
        bus_a.prog_data  = p_data;
        fidx = int'(f_addr >> 2);
        pidx = int'(p_addr >> 2);
        if (f_en) begin
            if (f_addr[1:0] == 2'b00 && fidx < 256) begin
                fe.data  = {32'h0, model_a[fidx]};
                fe.fault = 1'b0;
            end else begin
                fe.data  = 64'h0;
                fe.fault = 1'b1;
            end
            exp_fa_q.push_back(fe);
        end
        if (p_en) begin
            if (p_addr[1:0] == 2'b00 && pidx < 256) begin
                model_a[pidx] = p_data;
                exp_pa_q.push_back(1'b0);
            end else begin
                exp_pa_q.push_back(1'b1);
            end
        end
        @(negedge clk);
        bus_a.fetch_req = 1'b0;
        bus_a.prog_we   = 1'b0;
    endtask

    // One cycle of stimulus on DUT B (8-byte words, 16 entries).
    task automatic drive_b(input bit f_en, input logic [21:0] f_addr, input bit p_en,
                           input logic [21:0] p_addr, input logic [63:0] p_data);
        fexp_t fe;
        int unsigned fidx;
        int unsigned pidx;
        bus_b.fetch_req  = f_en;
        bus_b.fetch_addr = f_addr;
        bus_b.prog_we    = p_en;
        bus_b.prog_addr  = p_addr;
        bus_b.prog_data  = p_data;
        fidx = int'(f_addr >> 3);
        pidx = int'(p_addr >> 3);
        if (f_en) begin
            if (f_addr[2:0] == 3'b000 && fidx < 16) begin
                fe.data  = model_b[fidx];
                fe.fault = 1'b0;
            end else begin
                fe.data  = 64'h0;
                fe.fault = 1'b1;
            end
            exp_fb_q.push_back(fe);
        end
        if (p_en) begin
            if (p_addr[2:0] == 3'b000 && pidx < 16) begin
                model_b[pidx] = p_data;
                exp_pb_q.push_back(1'b0);
            end else begin
                exp_pb_q.push_back(1'b1);
            end
        end
        @(negedge clk);
        bus_b.fetch_req = 1'b0;
        bus_b.prog_we   = 1'b0;
    endtask

    // Measure the clear sequence of DUT A from the current negedge.
    task automatic wait_clear_a(input bit noisy, output int busy, output int ready_hi, output int act);
        busy = 0;
        ready_hi = 0;
        act = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus_a.init_busy !== 1'b1) break;
            busy++;
            if (bus_a.fetch_ready !== 1'b0) ready_hi++;
            if (bus_a.fetch_valid !== 1'b0 || bus_a.prog_ack !== 1'b0) act++;
            bus_a.fetch_req  = noisy;
            bus_a.prog_we    = noisy;
            bus_a.fetch_addr = 22'($urandom_range(0, 1023));
            bus_a.prog_addr  = 22'($urandom_range(0, 255) * 4);
            bus_a.prog_data  = $urandom;
            @(negedge clk);
        end
        bus_a.fetch_req = 1'b0;
        bus_a.prog_we   = 1'b0;
        for (int i = 0; i < 256; i++) model_a[i] = 32'h0;
    endtask

    task automatic test_reset();
        int busy, rdy, act;
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_a.fetch_valid !== 1'b0 || bus_a.prog_ack !== 1'b0 || bus_a.prog_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a_flags: valid=%b ack=%b err=%b, required 0 0 0",
                     bus_a.fetch_valid, bus_a.prog_ack, bus_a.prog_err);
        end
        n_checks++;
        if (bus_a.fetch_data !== 32'h0 || bus_a.fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a_data: data=%h fault=%b, required 0 0", bus_a.fetch_data, bus_a.fetch_fault);
        end
        n_checks++;
        if (bus_a.init_busy !== 1'b1 || bus_a.fetch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a_state: busy=%b ready=%b, required 1 0", bus_a.init_busy, bus_a.fetch_ready);
        end
        n_checks++;
        if (bus_b.init_busy !== 1'b0 || bus_b.fetch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_b_state: busy=%b ready=%b, required 0 1", bus_b.init_busy, bus_b.fetch_ready);
        end
        reset_a = 1'b0;
        reset_b = 1'b0;
        wait_clear_a(1'b0, busy, rdy, act);
        n_checks++;
        if (busy != 256 || rdy != 0) begin
            n_fail++;
            $display("FAIL initial_clear: busy_cycles=%0d ready_high=%0d, required 256 0", busy, rdy);
        end
    endtask

    task automatic test_reset_clear();
        int busy, rdy, act;
        drive_a(1'b0, 22'h0, 1'b1, 22'h14, 32'hCAFE_F00D);
        drive_a(1'b1, 22'h14, 1'b0, 22'h0, 32'h0);
        reset_a = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.fetch_valid !== 1'b0 || bus_a.fetch_data !== 32'h0 || bus_a.init_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse_reset: valid=%b data=%h busy=%b, required 0 00000000 1",
                     bus_a.fetch_valid, bus_a.fetch_data, bus_a.init_busy);
        end
        reset_a = 1'b0;
        wait_clear_a(1'b0, busy, rdy, act);
        n_checks++;
        if (busy != 256 || rdy != 0) begin
            n_fail++;
            $display("FAIL reset_clear_len: busy_cycles=%0d ready_high=%0d, required 256 0", busy, rdy);
        end
        drive_a(1'b1, 22'h14, 1'b0, 22'h0, 32'h0);
    endtask

    task automatic test_load_fetch();
        drive_a(1'b0, 22'h0, 1'b1, 22'h0, 32'hDEAD_BEEF);
        drive_a(1'b0, 22'h0, 1'b1, 22'h3FC, 32'h1234_5678);
        drive_a(1'b1, 22'h0, 1'b0, 22'h0, 32'h0);
        drive_a(1'b1, 22'h3FC, 1'b0, 22'h0, 32'h0);
        n_checks++;
        if (bus_a.fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_valid: fetch_valid=%b, required 1", bus_a.fetch_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus_a.fetch_valid !== 1'b0 || bus_a.fetch_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL idle_hold: valid=%b data=%h, required 0 12345678", bus_a.fetch_valid, bus_a.fetch_data);
        end
    endtask

    task automatic test_faults();
        drive_a(1'b1, 22'h2, 1'b0, 22'h0, 32'h0);
        drive_a(1'b1, 22'h400, 1'b0, 22'h0, 32'h0);
        drive_a(1'b0, 22'h0, 1'b1, 22'h401, 32'hBAD0_0001);
        drive_a(1'b0, 22'h0, 1'b1, 22'h400, 32'hBAD0_0002);
        drive_a(1'b0, 22'h0, 1'b1, 22'h3, 32'hBAD0_0003);
        drive_a(1'b1, 22'h0, 1'b0, 22'h0, 32'h0);
        drive_a(1'b1, 22'h3FFFFC, 1'b0, 22'h0, 32'h0);
        drive_a(1'b1, 22'h3FC, 1'b0, 22'h0, 32'h0);
    endtask

    task automatic test_collision();
        drive_a(1'b0, 22'h0, 1'b1, 22'hC, 32'hAAAA_0000);
        drive_a(1'b1, 22'hC, 1'b1, 22'hC, 32'h5555_0000);
        drive_a(1'b1, 22'hC, 1'b0, 22'h0, 32'h0);
        drive_a(1'b1, 22'h10, 1'b1, 22'h8, 32'h0BAD_CAFE);
        drive_a(1'b1, 22'h8, 1'b0, 22'h0, 32'h0);
    endtask

    task automatic test_mid_clear_reset();
        int busy, rdy, act;
        int act_pre;
        act_pre = 0;
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_a.fetch_valid !== 1'b0 || bus_a.prog_ack !== 1'b0) act_pre++;
            bus_a.fetch_req  = 1'b1;
            bus_a.prog_we    = 1'b1;
            bus_a.fetch_addr = 22'($urandom_range(0, 255) * 4);
            bus_a.prog_addr  = 22'($urandom_range(0, 255) * 4);
            bus_a.prog_data  = $urandom;
            @(negedge clk);
        end
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        wait_clear_a(1'b1, busy, rdy, act);
        n_checks++;
        if (busy != 256 || rdy != 0) begin
            n_fail++;
            $display("FAIL mid_clear_len: busy_cycles=%0d ready_high=%0d, required 256 0", busy, rdy);
        end
        n_checks++;
        if (act + act_pre != 0) begin
            n_fail++;
            $display("FAIL clear_ignores_req: responses=%0d, required 0", act + act_pre);
        end
        drive_a(1'b1, 22'h0, 1'b0, 22'h0, 32'h0);
        drive_a(1'b1, 22'h3FC, 1'b0, 22'h0, 32'h0);
        drive_a(1'b1, 22'hC, 1'b0, 22'h0, 32'h0);
    endtask

    task automatic test_no_clear_64();
        drive_b(1'b0, 22'h0, 1'b1, 22'h8, 64'h0123_4567_89AB_CDEF);
        drive_b(1'b0, 22'h0, 1'b1, 22'h0, 64'hFEDC_BA98_7654_3210);
        drive_b(1'b1, 22'h8, 1'b0, 22'h0, 64'h0);
        reset_b = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_b.fetch_ready !== 1'b1 || bus_b.init_busy !== 1'b0 || bus_b.fetch_valid !== 1'b0
            || bus_b.fetch_data !== 64'h0) begin
            n_fail++;
            $display("FAIL b_reset: ready=%b busy=%b valid=%b data=%h, required 1 0 0 0",
                     bus_b.fetch_ready, bus_b.init_busy, bus_b.fetch_valid, bus_b.fetch_data);
        end
        reset_b = 1'b0;
        drive_b(1'b1, 22'h8, 1'b0, 22'h0, 64'h0);
        drive_b(1'b1, 22'h0, 1'b0, 22'h0, 64'h0);
        drive_b(1'b1, 22'h4, 1'b0, 22'h0, 64'h0);
        drive_b(1'b1, 22'h80, 1'b0, 22'h0, 64'h0);
        drive_b(1'b0, 22'h0, 1'b1, 22'h80, 64'hBADB_ADBA_DBAD_BAD0);
        drive_b(1'b0, 22'h0, 1'b1, 22'h4, 64'hBADB_ADBA_DBAD_BAD1);
        drive_b(1'b1, 22'h0, 1'b0, 22'h0, 64'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_a  = 1'b1;
        reset_b  = 1'b1;
        bus_a.fetch_req = 1'b0; bus_a.fetch_addr = '0; bus_a.prog_we = 1'b0;
        bus_a.prog_addr = '0;   bus_a.prog_data = '0;
        bus_b.fetch_req = 1'b0; bus_b.fetch_addr = '0; bus_b.prog_we = 1'b0;
        bus_b.prog_addr = '0;   bus_b.prog_data = '0;
        for (int i = 0; i < 256; i++) model_a[i] = 32'h0;
        for (int i = 0; i < 16; i++) model_b[i] = 64'h0;

        test_reset();
        test_reset_clear();
        test_load_fetch();
        test_faults();
        test_collision();
        test_mid_clear_reset();
        test_no_clear_64();

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_fa_q.size() != 0 || exp_pa_q.size() != 0 || exp_fb_q.size() != 0 || exp_pb_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_responses: pending fa=%0d pa=%0d fb=%0d pb=%0d, required all 0",
                     exp_fa_q.size(), exp_pa_q.size(), exp_fb_q.size(), exp_pb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised synchronous instruction memory for the CPU fetch stage. It replaces the combinational-read, level-triggered-clear memory.
- Adds a registered fetch port with a valid handshake and a program-load write port. An init FSM clears the array sequentially after reset.
- Performs alignment and range checking on both ports.
- Sits between the fetch unit and the boot/program loader.

Parameters:
- DEPTH, 256: number of instruction words (any value ≥ 2).
- DATA_W, 32: instruction word width; legal values are 32 and 64.
- ADDR_W, 22: byte-address width on both ports.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = array contents are kept across reset.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- fetch_req, in, 1: fetch request, sampled when fetch_ready = 1.
- fetch_addr, in, ADDR_W: byte address of the instruction.
- fetch_ready, out, 1: block can accept a fetch (state == RUN).
- fetch_valid, out, 1: fetch_data and fetch_fault are valid this cycle.
- fetch_data, out, DATA_W: instruction word.
- fetch_fault, out, 1: the accepted fetch was misaligned or out of range.
- prog_we, in, 1: program-load write strobe.
- prog_addr, in, ADDR_W: byte address of the write.
- prog_data, in, DATA_W: word to write.
- prog_ack, out, 1: one-cycle pulse acknowledging an accepted prog_we.
- prog_err, out, 1: qualifies prog_ack; the write was dropped because of misalignment or range.
- init_busy, out, 1: clear sequence in progress.

Behaviour:
- Address decoding:
  - OFF = clog2(DATA_W/8).
  - Word index = addr[ADDR_W-1:OFF].
  - Misaligned when addr[OFF-1:0] != 0.
  - Out of range when index >= DEPTH; compare the full index, not a truncated one.
- Reset (synchronous, while reset = 1):
  - fetch_valid = 0, fetch_data = 0, fetch_fault = 0, prog_ack = 0, prog_err = 0.
  - State = CLEAR when CLEAR_ON_RESET = 1, otherwise RUN.
  - Clear counter = 0.
- FSM states:
  - CLEAR: writes 0 to mem[cnt] and increments cnt, one word per cycle. After the write at cnt == DEPTH-1 the state goes to RUN. After reset deasserts, RUN is entered after exactly DEPTH cycles.
  - RUN: normal operation; no exit except reset.
  - Reset asserted mid-CLEAR restarts the counter at 0.
- Outputs during CLEAR:
  - init_busy = 1, fetch_ready = 0.
  - fetch_req and prog_we are ignored: no valid, no ack, no memory change.
- Combinational outputs: fetch_ready = (state == RUN); init_busy = (state == CLEAR). Both are combinational from the state register.
- Fetch path (one-cycle latency):
  - When fetch_req and fetch_ready are both high in cycle N, fetch_valid = 1 in cycle N+1.
  - Legal request: fetch_data = mem[index] and fetch_fault = 0.
  - Faulting request: fetch_data = 0 and fetch_fault = 1.
  - Back-to-back requests are accepted every cycle (full throughput).
  - When no request is accepted, fetch_valid = 0 and fetch_data/fetch_fault hold their last values.
- Program write:
  - When prog_we is high in RUN in cycle N: if legal, mem[index] = prog_data at the cycle-N edge. prog_ack = 1 in cycle N+1 for one cycle.
  - prog_err = 1 in cycle N+1 if the write was dropped.
  - Consecutive writes each get their own ack.
- Read/write collision: fetch and prog_we to the same index in the same cycle is read-first. The fetch returns the old word; a fetch in the next cycle returns the new word.
- The array is inferred as a RAM: one write port and one synchronous read port. There is no per-entry reset loop. The CLEAR FSM shares the write port, with CLEAR having priority.

Decomposition:
- Package imem_pkg:
  - State enum {CLEAR, RUN}.
  - Default DEPTH, DATA_W and ADDR_W constants.
  - The NOP/zero fault-word constant.
  - Function computing OFF from DATA_W.
- Sub-module imem_ram:
  - Parametrised DEPTH × DATA_W array.
  - One write port (we, waddr, wdata) and one registered read port (re, raddr, rdata), read-first.
  - The top level holds the FSM, counter, decode and handshake logic.

Test Plan:
- Reset clear: preload mem[5] via the write port with CLEAR_ON_RESET = 1, pulse reset for 1 cycle. init_busy stays high for exactly 256 cycles and fetch_ready = 0 throughout. Fetch 0x14 afterwards returns 0x00000000 with fetch_fault = 0.
- Load/fetch: prog writes 0xDEADBEEF at 0x0 and 0x12345678 at 0x3FC. prog_ack pulses twice with prog_err = 0. Back-to-back fetches of 0x0 and 0x3FC return those words on consecutive cycles with fetch_valid = 1.
- Faults: fetch 0x2 gives fetch_fault = 1 and data 0. Fetch 0x400 (index 256) gives fetch_fault = 1. prog_we to 0x401 gives prog_ack = 1, prog_err = 1, and memory is unchanged.
- Collision: mem[3] = 0xAAAA0000. In the same cycle, write 0x55550000 to 0xC and fetch 0xC: the fetch returns 0xAAAA0000. The next fetch of 0xC returns 0x55550000.
- Mid-clear reset: assert reset at clear cycle 100. The counter restarts, and init_busy then lasts a full 256 cycles from the new reset release. fetch_req/prog_we driven during CLEAR produce no fetch_valid and no prog_ack.
- CLEAR_ON_RESET = 0, DATA_W = 64: reset gives fetch_ready = 1 on the next cycle and prior contents survive. Fetch 0x8 returns the word at index 1. Fetch 0x4 faults as misaligned.
